// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path.
// State encodings and default timing parameters.
package uart_pkg;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_START = 2'd1;
    localparam logic [1:0] WAIT_DONE  = 2'd2;

    localparam int BUSY_TIMEOUT_DEF = 8;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Request and transmitter bundle for uart_tx_arb.
// master = arbiter side, slave = producers / transmitter side.
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_send;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic [2:0]         grant_id;
    logic               active;
    logic               err;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_send, tx_data, grant_id, active, err
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_send, tx_data, grant_id, active, err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns one-hot grant and index of first request after 'last'.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] pos;

    // Scan last+1, last+2, ... with wrap; first set bit wins
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(last) + k) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// Simple 8N1 UART byte transmitter.
// Busy rises the cycle after send and falls after the stop bit.
module uart_tx_byte #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CKW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    logic           busy_q, busy_d;
    logic [9:0]     shift_q, shift_d;
    logic [3:0]     bit_q, bit_d;
    logic [CKW-1:0] ck_q, ck_d;

    // Load frame on send, then shift one bit every CLK_PER_BIT cycles
    always_comb begin
        busy_d  = busy_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        ck_d    = ck_q;
        if (!busy_q) begin
            if (send) begin
                busy_d  = 1'b1;
                shift_d = {1'b1, data, 1'b0};
                bit_d   = '0;
                ck_d    = '0;
            end
        end else if (ck_q == CKW'(CLK_PER_BIT - 1)) begin
            ck_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
            end else begin
                bit_d   = bit_q + 4'd1;
                shift_d = {1'b1, shift_q[9:1]};
            end
        end else begin
            ck_d = ck_q + CKW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            shift_q <= '1;
            bit_q   <= '0;
            ck_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            ck_q    <= ck_d;
        end
    end

    assign busy = busy_q;
    assign tx   = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx_byte between N_REQ producers.
// Latches the winning byte, pulses send, then tracks busy to frame end.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_arb_if.master bus
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [2:0]    grant_q, grant_d;
    logic          active_q, active_d;
    logic          send_q, send_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    logic             can_grant;
    logic [7:0]       data_sel;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (bus.req_valid),
        .last  (last_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign can_grant = rst_n && (state_q == IDLE) && !bus.tx_busy && pick_found;

    // One-hot select of the winning requester's byte
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) data_sel = bus.req_data[8*i +: 8];
        end
    end

    // Arbitration FSM with busy-rise timeout
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        send_d    = 1'b0;
        err_d     = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (can_grant) begin
                    tx_data_d = data_sel;
                    grant_d   = 3'(pick_idx);
                    last_d    = pick_idx;
                    active_d  = 1'b1;
                    send_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_START;
                end
            end
            (state_q == WAIT_START): begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            (state_q == WAIT_DONE): begin
                if (!bus.tx_busy) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State registers; reset leaves the transmitter running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= IW'(N_REQ - 1);
            tx_data_q <= '0;
            grant_q   <= '0;
            active_q  <= 1'b0;
            send_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            active_q  <= active_d;
            send_q    <= send_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.req_ready = can_grant ? pick_grant : '0;
    assign bus.tx_send   = send_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.active    = active_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed testbench for uart_tx_arb driving a real uart_tx_byte.
// Each task runs one scenario and checks its own expectations.
module tb_uart_tx_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_rst_n = 1'b0;
    logic       kill = 1'b0;
    logic       byte_busy;
    logic       ser;
    int         checks = 0;
    int         failures = 0;
    int         n_acc;
    int         n_sends;
    logic [2:0] got_id [8];
    logic [7:0] got_data [8];

    always #5 clk = ~clk;

    uart_tx_arb_if #(.N_REQ(4)) bus ();

    uart_tx_arb #(
        .N_REQ        (4),
        .BUSY_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    uart_tx_byte #(.CLK_PER_BIT(4)) u_tx (
        .clk   (clk),
        .rst_n (tx_rst_n),
        .send  (bus.tx_send & ~kill),
        .data  (bus.tx_data),
        .busy  (byte_busy),
        .tx    (ser)
    );

    assign bus.tx_busy = kill ? 1'b0 : byte_busy;

    task automatic arb_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (!bus.active) break;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s: active still %b after 200 cycles, want 0", name, bus.active);
        end
    endtask

    task automatic collect(input int n, input logic [3:0] start, input logic [3:0] keep);
        logic [3:0] clr;
        int         b;
        n_acc   = 0;
        n_sends = 0;
        clr     = '0;
        @(negedge clk);
        bus.req_valid = start;
        for (b = 0; b < 3000; b++) begin
            #1;
            if (bus.tx_send) begin
                if (n_sends < 8) begin
                    got_id[n_sends]   = bus.grant_id;
                    got_data[n_sends] = bus.tx_data;
                end
                n_sends++;
            end
            if (n_sends >= n && !bus.active) break;
            clr = bus.req_ready & bus.req_valid & ~keep;
            if ((bus.req_ready & bus.req_valid) != 4'b0) n_acc++;
            @(negedge clk);
            bus.req_valid = bus.req_valid & ~clr;
        end
        bus.req_valid = '0;
        checks++;
        if (b >= 3000) begin
            failures++;
            $display("FAIL collect_timeout: sends=%0d want %0d", n_sends, n);
        end
    endtask

    task automatic test_reset();
        int sends;
        int readies;
        bus.req_valid = '0;
        bus.req_data  = '0;
        rst_n    = 1'b0;
        tx_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        tx_rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0 || bus.tx_send !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: ready=%b send=%b err=%b want 0/0/0",
                     bus.req_ready, bus.tx_send, bus.err);
        end
        checks++;
        if (bus.tx_data !== 8'h00 || bus.grant_id !== 3'd0 || bus.active !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: data=%h id=%0d active=%b want 00/0/0",
                     bus.tx_data, bus.grant_id, bus.active);
        end
        sends = 0;
        readies = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (bus.tx_send) sends++;
            if (bus.req_ready != 4'b0 || bus.active) readies++;
        end
        checks++;
        if (sends != 0 || readies != 0) begin
            failures++;
            $display("FAIL reset_idle: sends=%0d busy_cycles=%0d want 0/0", sends, readies);
        end
    endtask

    task automatic test_single();
        logic [7:0] rx;
        int         n;
        @(negedge clk);
        bus.req_data[23:16] = 8'h41;
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100 || bus.tx_send !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: ready=%b send=%b want 0100/0", bus.req_ready, bus.tx_send);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.tx_send !== 1'b1 || bus.tx_data !== 8'h41 || bus.grant_id !== 3'd2
            || bus.active !== 1'b1 || bus.req_ready !== 4'b0) begin
            failures++;
            $display("FAIL single_send: send=%b data=%h id=%0d active=%b ready=%b want 1/41/2/1/0000",
                     bus.tx_send, bus.tx_data, bus.grant_id, bus.active, bus.req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.tx_send !== 1'b0 || ser !== 1'b0) begin
            failures++;
            $display("FAIL single_start: send=%b ser=%b want 0/0", bus.tx_send, ser);
        end
        rx = '0;
        for (int k = 0; k < 8; k++) begin
            repeat (4) @(negedge clk);
            #1;
            rx[k] = ser;
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (rx !== 8'h41 || ser !== 1'b1) begin
            failures++;
            $display("FAIL single_serial: byte=%h stop=%b want 41/1", rx, ser);
        end
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (!bus.tx_busy) break;
        end
        checks++;
        if (n >= 10 || bus.active !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_fall: waited=%0d active=%b want <10/1", n, bus.active);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.active !== 1'b0) begin
            failures++;
            $display("FAIL single_active_drop: active=%b want 0", bus.active);
        end
    endtask

    task automatic test_round_robin();
        arb_reset();
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int r = 0; r < 2; r++) begin
            collect(4, 4'b1111, 4'b0000);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_id[i] !== 3'(i) || got_data[i] !== 8'(8'h10 + i)) begin
                    failures++;
                    $display("FAIL rr_order r%0d g%0d: id=%0d data=%h want %0d/%h",
                             r, i, got_id[i], got_data[i], i, 8'h10 + i);
                end
            end
            checks++;
            if (n_sends != 4 || n_acc != 4) begin
                failures++;
                $display("FAIL rr_counts r%0d: sends=%0d accepts=%0d want 4/4", r, n_sends, n_acc);
            end
        end
    endtask

    task automatic test_fairness();
        arb_reset();
        bus.req_data = {8'h23, 8'h00, 8'h21, 8'h00};
        @(negedge clk);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        #1;
        checks++;
        if (bus.tx_send !== 1'b1 || bus.grant_id !== 3'd1) begin
            failures++;
            $display("FAIL hog_first: send=%b id=%0d want 1/1", bus.tx_send, bus.grant_id);
        end
        repeat (12) @(negedge clk);
        collect(2, 4'b1010, 4'b0010);
        checks++;
        if (got_id[0] !== 3'd3 || got_id[1] !== 3'd1
            || got_data[0] !== 8'h23 || got_data[1] !== 8'h21) begin
            failures++;
            $display("FAIL hog_order: ids=%0d,%0d data=%h,%h want 3,1 23,21",
                     got_id[0], got_id[1], got_data[0], got_data[1]);
        end
        collect(2, 4'b0010, 4'b0010);
        checks++;
        if (got_id[0] !== 3'd1 || got_id[1] !== 3'd1 || n_sends != 2) begin
            failures++;
            $display("FAIL hog_alone: ids=%0d,%0d sends=%0d want 1,1 2",
                     got_id[0], got_id[1], n_sends);
        end
    endtask

    task automatic test_timeout();
        int c;
        int errs;
        arb_reset();
        kill = 1'b1;
        bus.req_data = {8'h00, 8'h77, 8'h00, 8'h55};
        @(negedge clk);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.tx_send !== 1'b1 || bus.tx_data !== 8'h55 || bus.grant_id !== 3'd0) begin
            failures++;
            $display("FAIL to_send: send=%b data=%h id=%0d want 1/55/0",
                     bus.tx_send, bus.tx_data, bus.grant_id);
        end
        for (c = 1; c <= 20; c++) begin
            @(negedge clk);
            #1;
            if (bus.err) break;
        end
        checks++;
        if (c != 9) begin
            failures++;
            $display("FAIL to_err_delay: err after %0d cycles want 9", c);
        end
        checks++;
        if (bus.active !== 1'b0 || bus.req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL to_err_state: active=%b ready=%b want 0/0100", bus.active, bus.req_ready);
        end
        kill = 1'b0;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.err !== 1'b0 || bus.tx_send !== 1'b1 || bus.grant_id !== 3'd2
            || bus.tx_data !== 8'h77) begin
            failures++;
            $display("FAIL to_next: err=%b send=%b id=%0d data=%h want 0/1/2/77",
                     bus.err, bus.tx_send, bus.grant_id, bus.tx_data);
        end
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (bus.err) errs++;
        end
        checks++;
        if (errs != 0 || bus.active !== 1'b0) begin
            failures++;
            $display("FAIL to_normal_frame: errs=%0d active=%b want 0/0", errs, bus.active);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int viol;
        arb_reset();
        bus.req_data = {8'h5A, 8'h00, 8'h00, 8'h30};
        @(negedge clk);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.tx_send !== 1'b1 || bus.grant_id !== 3'd3) begin
            failures++;
            $display("FAIL mid_send: send=%b id=%0d want 1/3", bus.tx_send, bus.grant_id);
        end
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.active !== 1'b0 || bus.tx_data !== 8'h00 || bus.grant_id !== 3'd0
            || bus.tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: active=%b data=%h id=%0d busy=%b want 0/00/0/1",
                     bus.active, bus.tx_data, bus.grant_id, bus.tx_busy);
        end
        rst_n = 1'b1;
        bus.req_valid = 4'b1001;
        viol = 0;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            #1;
            if (!bus.tx_busy) break;
            if (bus.req_ready != 4'b0) viol++;
        end
        checks++;
        if (n >= 60 || viol != 0) begin
            failures++;
            $display("FAIL mid_hold: waited=%0d ready_while_busy=%0d want <60/0", n, viol);
        end
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_prio: ready=%b want 0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.tx_send !== 1'b1 || bus.grant_id !== 3'd0 || bus.tx_data !== 8'h30) begin
            failures++;
            $display("FAIL mid_grant: send=%b id=%0d data=%h want 1/0/30",
                     bus.tx_send, bus.grant_id, bus.tx_data);
        end
        wait_idle("mid_idle");
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
